ula_multiciclo: RTL and testbench

- Parametrised, registered successor to the combinational 32-bit ULA.
- Executes the same 3-bit op set (AND/OR/ADD/SUB/SLT), and adds XOR plus iterative unsigned multiply and divide.
- Sits between the register-file read stage and writeback, with a valid/ready handshake on both sides so the datapath can stall on multi-cycle ops.

---
 rtl/ula_multiciclo.sv | 174 +++++++++++++++++
 tb/tb_ula_multiciclo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ALU with valid/ready handshake and iterative MULU/DIVU.
// Optional `ULA_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.
module ula_multiciclo #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] entrada_01,
    input  logic [WIDTH-1:0] entrada_02,
    input  logic [2:0]       ULA_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ULA_result,
    output logic [WIDTH-1:0] ULA_result_hi,
    output logic             Zero,
`ifdef ULA_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             div_zero
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] m_reg, hi_reg, lo_reg;
    logic             is_div;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum, diff, sc_lo, sc_hi, step_hi, step_lo;
    logic             div0, multi;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
`ifdef ULA_OVERFLOW_EN
    logic             sc_ovf;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle results come straight from the inputs at the accept edge.
    always_comb begin
        sum   = entrada_01 + entrada_02;
        diff  = entrada_01 - entrada_02;
        div0  = (ULA_control == OP_DIVU) && (entrada_02 == '0);
        multi = (ULA_control == OP_MULU) || ((ULA_control == OP_DIVU) && !div0);
        sc_lo = '0;
        sc_hi = '0;
`ifdef ULA_OVERFLOW_EN
        sc_ovf = 1'b0;
`endif
        case (ULA_control)
            OP_AND:  sc_lo = entrada_01 & entrada_02;
            OP_OR:   sc_lo = entrada_01 | entrada_02;
            OP_ADD: begin
                sc_lo = sum;
`ifdef ULA_OVERFLOW_EN
                sc_ovf = (entrada_01[WIDTH-1] == entrada_02[WIDTH-1]) &&
                         (sum[WIDTH-1] != entrada_01[WIDTH-1]);
`endif
            end
            OP_SUB: begin
                sc_lo = diff;
`ifdef ULA_OVERFLOW_EN
                sc_ovf = (entrada_01[WIDTH-1] != entrada_02[WIDTH-1]) &&
                         (diff[WIDTH-1] != entrada_01[WIDTH-1]);
`endif
            end
            OP_SLT:  sc_lo = WIDTH'($signed(entrada_01) < $signed(entrada_02));
            OP_XOR:  sc_lo = entrada_01 ^ entrada_02;
            OP_DIVU: begin
                sc_lo = '1;
                sc_hi = entrada_01;
            end
            OP_MULU: sc_lo = '0;
        endcase
    end

    // One iteration: shift-add multiply (hi:lo product, multiplier in lo) or
    // restoring divide (remainder in hi, dividend/quotient shifting through lo).
    always_comb begin
        step_hi   = hi_reg;
        step_lo   = lo_reg;
        mul_sum   = {1'b0, hi_reg} + {1'b0, m_reg};
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_reg};
        if (is_div) begin
            if (div_diff[WIDTH]) begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_reg[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_reg[WIDTH-2:0], 1'b1};
            end
        end else if (lo_reg[0]) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, hi_reg[WIDTH-1:1]};
            step_lo = {hi_reg[0], lo_reg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = multi ? BUSY : DONE;
            BUSY: if (cnt == CNT_W'(1)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            is_div        <= 1'b0;
            cnt           <= '0;
            ULA_result    <= '0;
            ULA_result_hi <= '0;
            Zero          <= 1'b0;
            div_zero      <= 1'b0;
`ifdef ULA_OVERFLOW_EN
            overflow      <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            div_zero <= div0;
            if (multi) begin
                is_div <= (ULA_control == OP_DIVU);
                m_reg  <= (ULA_control == OP_DIVU) ? entrada_02 : entrada_01;
                lo_reg <= (ULA_control == OP_DIVU) ? entrada_01 : entrada_02;
                hi_reg <= '0;
                cnt    <= CNT_W'(WIDTH);
            end else begin
                ULA_result    <= sc_lo;
                ULA_result_hi <= sc_hi;
                Zero          <= (sc_lo == '0);
`ifdef ULA_OVERFLOW_EN
                overflow      <= sc_ovf;
`endif
            end
        end else if (state == BUSY) begin
            hi_reg <= step_hi;
            lo_reg <= step_lo;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                ULA_result    <= step_lo;
                ULA_result_hi <= step_hi;
                Zero          <= (step_lo == '0);
`ifdef ULA_OVERFLOW_EN
                overflow      <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus randomized ops
// against an arithmetic reference model; honours `ULA_OVERFLOW_EN.
module tb_ula_multiciclo;

    localparam int W = 32;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, Zero, div_zero;
    logic [W-1:0] entrada_01, entrada_02, ULA_result, ULA_result_hi;
    logic [2:0]   ULA_control;
`ifdef ULA_OVERFLOW_EN
    logic         overflow;
`endif

    int n_vec = 0;
    int n_bad = 0;

    ula_multiciclo #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .entrada_01(entrada_01),
        .entrada_02(entrada_02),
        .ULA_control(ULA_control),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ULA_result(ULA_result),
        .ULA_result_hi(ULA_result_hi),
        .Zero(Zero),
`ifdef ULA_OVERFLOW_EN
        .overflow(overflow),
`endif
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation definitions.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] lo, hi, output logic dz, ovf,
                                  output int lat);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        lo = '0; hi = '0; dz = 1'b0; ovf = 1'b0; lat = 1;
        case (op)
            OP_AND: lo = a & b;
            OP_OR:  lo = a | b;
            OP_XOR: lo = a ^ b;
            OP_ADD: begin
                r = a + b; lo = r;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r = a - b; lo = r;
                ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SLT: lo = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_MULU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                lo = p[W-1:0]; hi = p[2*W-1:W]; lat = W + 1;
            end
            OP_DIVU: begin
                if (b == 0) begin
                    lo = '1; hi = a; dz = 1'b1;
                end else begin
                    lo = a / b; hi = a % b; lat = W + 1;
                end
            end
        endcase
    endfunction

    // Issue one op, time it, check results, hold under back-pressure for `hold`
    // cycles (offering an ignored op meanwhile), then release.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, input int hold);
        logic [W-1:0] elo, ehi;
        logic         edz, eovf, saw_ready;
        int           elat, lat;
        model(op, a, b, elo, ehi, edz, eovf, elat);
        check("idle_ready", in_ready, 1);
        ULA_control = op; entrada_01 = a; entrada_02 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        entrada_01 = $urandom; entrada_02 = $urandom; ULA_control = 3'($urandom_range(7, 0));
        lat = 1; saw_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, elat);
        check("ready_in_busy", saw_ready, 0);
        check("result", ULA_result, elo);
        check("result_hi", ULA_result_hi, ehi);
        check("zero", Zero, (elo == 0));
        check("div_zero", div_zero, edz);
`ifdef ULA_OVERFLOW_EN
        check("overflow", overflow, eovf);
`endif
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_result", ULA_result, elo);
            check("hold_hi", ULA_result_hi, ehi);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("released_valid", out_valid, 0);
        check("released_result", ULA_result, elo);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        entrada_01 = '0; entrada_02 = '0; ULA_control = OP_AND;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", ULA_result, 0);
        check("rst_zero", Zero, 0);
        reset = 1'b0;

        run_op(OP_ADD, 32'h0000000F, 32'h00000001, 0);
        run_op(OP_SUB, 32'h0000000F, 32'h0000000F, 0);
        run_op(OP_SLT, 32'h0000000A, 32'h0000000F, 0);
        run_op(OP_SLT, 32'h80000000, 32'h00000001, 0);
        run_op(OP_SLT, 32'h00000001, 32'h80000000, 0);
        run_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(OP_DIVU, 32'd100, 32'd7, 0);
        run_op(OP_DIVU, 32'd5, 32'd0, 0);
        run_op(OP_XOR, 32'h12345678, 32'h0F0F0F0F, 0);
        run_op(OP_AND, 32'hA5A5A5A5, 32'h5A5A5A5A, 5);
        run_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 0);
        run_op(OP_SUB, 32'h80000000, 32'h00000001, 1);
        run_op(OP_DIVU, 32'h00000003, 32'hFFFFFFFF, 0);

        // Reset while a multiply is in flight.
        ULA_control = OP_MULU; entrada_01 = 32'h1234; entrada_02 = 32'h5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", ULA_result, 0);
        check("midrst_result_hi", ULA_result_hi, 0);
        check("midrst_zero", Zero, 0);
        check("midrst_div_zero", div_zero, 0);
        run_op(OP_ADD, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(3, 0) == 0) ? W'($urandom_range(20, 0)) : W'($urandom);
            run_op(3'($urandom_range(7, 0)), ra, rb, $urandom_range(2, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
